// File: rtl/bcrypt_word_unpack_pkg.sv
// Shared types and sizing helpers for the bcrypt word unpacker.
// Provides the output-stage state type and clog2-based width functions.
package bcrypt_word_unpack_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } unpack_state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r = r + 1;
        return r;
    endfunction

    // Chunk counter width; at least one bit even when K == 1.
    function automatic int cc_width(input int k);
        return (k <= 1) ? 1 : clog2(k);
    endfunction

    // FIFO occupancy width: must hold the value DEPTH itself.
    function automatic int count_width(input int depth);
        return clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/bcrypt_word_fifo.sv
// Synchronous word FIFO with registered occupancy count.
// Ports: CLK, rst (sync, active-high), push/wr_data, pop,
//        head (oldest word), count, full, empty.
module bcrypt_word_fifo
    import bcrypt_word_unpack_pkg::*;
#(
    parameter int N     = 32,
    parameter int DEPTH = 4,
    localparam int AW   = clog2(DEPTH),
    localparam int CW   = count_width(DEPTH)
) (
    input  logic          CLK,
    input  logic          rst,
    input  logic          push,
    input  logic [N-1:0]  wr_data,
    input  logic          pop,
    output logic [N-1:0]  head,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    logic [N-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;

    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/bcrypt_word_unpack.sv
// Word-to-chunk unpacker: buffers N-bit words, emits N/OUT_WIDTH chunks LSB first.
// Ports: CLK, rst (sync, active-high); in_data/in_valid/in_ready word input;
//        out_data/out_valid/out_ready chunk output; empty (nothing buffered or in flight).
module bcrypt_word_unpack
    import bcrypt_word_unpack_pkg::*;
#(
    parameter int N         = 32,
    parameter int OUT_WIDTH = 8,
    parameter int DEPTH     = 4
) (
    input  logic                 CLK,
    input  logic                 rst,
    input  logic [N-1:0]         in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 empty
);

    localparam int K   = N / OUT_WIDTH;
    localparam int CCW = cc_width(K);
    localparam int CW  = count_width(DEPTH);
    localparam logic [CCW-1:0] LAST = CCW'(K - 1);

    unpack_state_e  state_q, state_d;
    logic [N-1:0]   sr_q, sr_d;
    logic [CCW-1:0] cc_q, cc_d;
    logic           in_ready_q;
    logic           empty_q;

    logic [N-1:0]   fifo_head;
    logic [CW-1:0]  fifo_count;
    logic [CW-1:0]  cnt_d;
    logic           fifo_full;
    logic           fifo_empty;
    logic           push;
    logic           pop;
    logic           bypass;
    logic           load_next;
    logic           accept;
    logic           consume;

    assign accept  = in_valid && in_ready_q;
    assign consume = (state_q == ST_SHIFT) && out_ready;

    bcrypt_word_fifo #(
        .N     (N),
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK     (CLK),
        .rst     (rst),
        .push    (push),
        .wr_data (in_data),
        .pop     (pop),
        .head    (fifo_head),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        cc_d      = cc_q;
        pop       = 1'b0;
        bypass    = 1'b0;
        load_next = 1'b0;

        unique case (state_q)
            ST_IDLE: load_next = 1'b1;
            ST_SHIFT: begin
                if (consume) begin
                    if (cc_q != LAST) begin
                        sr_d = sr_q >> OUT_WIDTH;
                        cc_d = cc_q + CCW'(1);
                    end else begin
                        load_next = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Buffered words take priority; a new word only skips the FIFO
        // when nothing older is waiting.
        if (load_next) begin
            cc_d = '0;
            if (!fifo_empty) begin
                sr_d    = fifo_head;
                pop     = 1'b1;
                state_d = ST_SHIFT;
            end else if (accept) begin
                sr_d    = in_data;
                bypass  = 1'b1;
                state_d = ST_SHIFT;
            end else begin
                state_d = ST_IDLE;
            end
        end

        push  = accept && !bypass && !fifo_full;
        cnt_d = fifo_count + CW'(push) - CW'(pop);
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            sr_q       <= '0;
            cc_q       <= '0;
            in_ready_q <= 1'b0;
            empty_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            cc_q       <= cc_d;
            in_ready_q <= (cnt_d != CW'(DEPTH));
            empty_q    <= (cnt_d == '0) && (state_d == ST_IDLE);
        end
    end

    assign out_data  = sr_q[OUT_WIDTH-1:0];
    assign out_valid = (state_q == ST_SHIFT);
    assign in_ready  = in_ready_q;
    assign empty     = empty_q;

endmodule

// File: tb/tb_bcrypt_word_unpack.sv
// Self-checking bench for bcrypt_word_unpack (K=4, K=2 and K=1 instances).
// Word-queue model checked every cycle plus directed literal expectations.
module tb_bcrypt_word_unpack;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        rst;
    logic [31:0] id  [3];
    logic        iv  [3];
    logic        orr [3];
    logic        ir  [3];
    logic        ov  [3];
    logic        em  [3];
    logic [31:0] od  [3];
    logic [7:0]  od0;
    logic [15:0] od1;
    logic [31:0] od2;

    assign od[0] = {24'h0, od0};
    assign od[1] = {16'h0, od1};
    assign od[2] = od2;

    bcrypt_word_unpack #(.N(32), .OUT_WIDTH(8), .DEPTH(4)) u0 (
        .CLK(CLK), .rst(rst), .in_data(id[0]), .in_valid(iv[0]),
        .in_ready(ir[0]), .out_data(od0), .out_valid(ov[0]),
        .out_ready(orr[0]), .empty(em[0])
    );

    bcrypt_word_unpack #(.N(32), .OUT_WIDTH(16), .DEPTH(4)) u1 (
        .CLK(CLK), .rst(rst), .in_data(id[1]), .in_valid(iv[1]),
        .in_ready(ir[1]), .out_data(od1), .out_valid(ov[1]),
        .out_ready(orr[1]), .empty(em[1])
    );

    bcrypt_word_unpack #(.N(32), .OUT_WIDTH(32), .DEPTH(4)) u2 (
        .CLK(CLK), .rst(rst), .in_data(id[2]), .in_valid(iv[2]),
        .in_ready(ir[2]), .out_data(od2), .out_valid(ov[2]),
        .out_ready(orr[2]), .empty(em[2])
    );

    int n_cmp = 0;
    int n_bad = 0;

    function automatic void chk(string nm, longint act, longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Model: words in acceptance order; front word's next chunk index.
    int          kk [3] = '{4, 2, 1};
    int          ow [3] = '{8, 16, 32};
    logic [31:0] wq [3][64];
    int          hd [3] = '{0, 0, 0};
    int          tl [3] = '{0, 0, 0};
    int          ci [3] = '{0, 0, 0};
    int          ncons [3] = '{0, 0, 0};
    bit          was_rst = 1'b1;
    int          cycles = 0;

    always @(posedge CLK) cycles <= cycles + 1;

    always @(negedge CLK) begin
        int     sz;
        int     occ;
        longint exp_chunk;
        for (int d = 0; d < 3; d++) begin
            sz = tl[d] - hd[d];
            if (was_rst) begin
                chk("rst_out_valid", longint'(ov[d]), 0);
                chk("rst_in_ready", longint'(ir[d]), 0);
                chk("rst_empty", longint'(em[d]), 1);
                chk("rst_out_data", longint'(od[d]), 0);
            end else begin
                occ = (sz > 0) ? sz - 1 : 0;
                chk("out_valid", longint'(ov[d]), longint'(sz != 0));
                chk("empty", longint'(em[d]), longint'(sz == 0));
                chk("in_ready", longint'(ir[d]), longint'(occ != 4));
                if (ov[d] && sz > 0) begin
                    exp_chunk = (longint'(wq[d][hd[d] % 64]) >> (ci[d] * ow[d]))
                              & ((64'd1 << ow[d]) - 1);
                    chk("out_data", longint'(od[d]), exp_chunk);
                end
            end
            if (rst) begin
                hd[d] = 0;
                tl[d] = 0;
                ci[d] = 0;
            end else begin
                if (ov[d] && orr[d]) begin
                    ncons[d]++;
                    if (sz > 0) begin
                        ci[d]++;
                        if (ci[d] == kk[d]) begin
                            ci[d] = 0;
                            hd[d]++;
                        end
                    end
                end
                if (iv[d] && ir[d]) begin
                    wq[d][tl[d] % 64] = id[d];
                    tl[d]++;
                end
            end
        end
        was_rst = rst;
    end

    task automatic cyc(int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic push(int d, logic [31:0] w);
        bit ok;
        ok = 1'b0;
        id[d] = w;
        iv[d] = 1'b1;
        for (int t = 0; t < 300 && !ok; t++) begin
            @(negedge CLK);
            ok = ir[d];
            @(posedge CLK);
            #1;
        end
        iv[d] = 1'b0;
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL push_timeout: dut %0d word %h never accepted", d, w);
        end
    endtask

    task automatic drain(int d);
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 300 && !ok; t++) begin
            @(negedge CLK);
            ok = em[d];
            @(posedge CLK);
            #1;
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: dut %0d never went empty", d);
        end
    endtask

    logic [7:0] e1  [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [7:0] e5  [4] = '{8'h04, 8'h03, 8'h02, 8'h01};
    bit         pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    int         c0;
    int         t0;

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            iv[d]  = 1'b0;
            orr[d] = 1'b1;
            id[d]  = '0;
        end
        cyc(3);
        @(negedge CLK);
        chk("reset_empty_lit", longint'(em[0]), 1);
        chk("reset_in_ready_lit", longint'(ir[0]), 0);
        @(posedge CLK);
        #1;
        rst = 1'b0;
        cyc(2);

        // Single word from idle, one chunk per cycle.
        push(0, 32'h44332211);
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            chk("t1_valid_lit", longint'(ov[0]), 1);
            chk("t1_chunk_lit", longint'(od0), longint'(e1[i]));
        end
        @(negedge CLK);
        chk("t1_done_valid_lit", longint'(ov[0]), 0);
        chk("t1_done_empty_lit", longint'(em[0]), 1);
        @(posedge CLK);
        #1;

        // Back-to-back words, no gap across the boundary.
        c0 = ncons[0];
        push(0, 32'hA3A2A1A0);
        push(0, 32'hB3B2B1B0);
        drain(0);
        chk("t2_chunk_count", longint'(ncons[0] - c0), 8);

        // Fill with a stalled consumer, then release.
        orr[0] = 1'b0;
        c0 = ncons[0];
        for (int w = 1; w <= 5; w++) push(0, 32'h0A0B0C00 | 32'(w));
        @(negedge CLK);
        chk("t3_full_in_ready_lit", longint'(ir[0]), 0);
        @(posedge CLK);
        #1;
        fork
            push(0, 32'h0A0B0C06);
            begin
                cyc(3);
                orr[0] = 1'b1;
            end
        join
        drain(0);
        chk("t3_chunk_count", longint'(ncons[0] - c0), 24);

        // Irregular consumer back-pressure.
        c0 = ncons[0];
        fork
            begin
                push(0, 32'hDDCCBBAA);
                push(0, 32'h11223344);
            end
            begin
                for (int i = 0; i < 30; i++) begin
                    orr[0] = pat[i % 6];
                    cyc(1);
                end
                orr[0] = 1'b1;
            end
        join
        drain(0);
        chk("t4_chunk_count", longint'(ncons[0] - c0), 8);

        // Reset mid-word with two words buffered.
        orr[0] = 1'b0;
        push(0, 32'hDDCCBBAA);
        push(0, 32'h55555555);
        push(0, 32'h66666666);
        orr[0] = 1'b1;
        cyc(2);
        rst = 1'b1;
        @(negedge CLK);
        chk("t5_third_chunk_lit", longint'(od0), 32'hCC);
        @(posedge CLK);
        #1;
        rst = 1'b0;
        @(negedge CLK);
        chk("t5_rst_valid_lit", longint'(ov[0]), 0);
        chk("t5_rst_ready_lit", longint'(ir[0]), 0);
        chk("t5_rst_empty_lit", longint'(em[0]), 1);
        @(posedge CLK);
        #1;
        push(0, 32'h01020304);
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            chk("t5_chunk_lit", longint'(od0), longint'(e5[i]));
        end
        @(negedge CLK);
        chk("t5_done_valid_lit", longint'(ov[0]), 0);
        @(posedge CLK);
        #1;

        // K=2 instance.
        push(1, 32'hCAFEBABE);
        @(negedge CLK);
        chk("k2_lo_lit", longint'(od1), 32'hBABE);
        @(negedge CLK);
        chk("k2_hi_lit", longint'(od1), 32'hCAFE);
        @(negedge CLK);
        chk("k2_done_lit", longint'(ov[1]), 0);
        @(posedge CLK);
        #1;

        // K=1 instance must sustain one word per cycle.
        c0 = ncons[2];
        t0 = cycles;
        for (int w = 0; w < 8; w++) push(2, 32'h70000000 + 32'(w * 3));
        chk("k1_accept_cycles", longint'(cycles - t0), 8);
        drain(2);
        chk("k1_word_count", longint'(ncons[2] - c0), 8);

        cyc(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
